// File: rtl/prog_loader_if.sv
// Byte-stream input, memory write port and boot status of the program loader.
// The loader side uses the master modport; the stream source/memory/cpu side uses slave.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
           cpu_reset, load_done, load_error, words_loaded
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
           cpu_reset, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a counted little-endian word stream, writes it to memory,
// verifies an 8-bit additive checksum and releases the cpu reset on success.
module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.master bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t                state_reg;
  logic [7:0]            n_lo_reg;
  logic [CNT_W-1:0]      n_reg;
  logic [1:0]            byte_idx_reg;
  logic [23:0]           asm_reg;
  logic [7:0]            csum_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [31:0]           mem_wdata_reg;
  logic [CNT_W-1:0]      words_loaded_reg;
  logic                  cpu_reset_reg;
  logic                  load_done_reg;
  logic                  load_error_reg;

  logic                  ready;
  logic                  accept;
  logic [15:0]           hdr_n;
  logic                  hdr_bad;
  logic                  last_word;

  assign ready     = !reset && (state_reg inside {HDR_LO, HDR_HI, DATA, CSUM});
  assign accept    = bus.in_valid && ready;
  assign hdr_n     = {bus.in_data, n_lo_reg};
  assign hdr_bad   = (hdr_n == 16'd0) || ({16'd0, hdr_n} > 32'(MEM_DEPTH));
  // words_loaded doubles as the word index while in DATA
  assign last_word = (words_loaded_reg + CNT_W'(1)) == n_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= HDR_LO;
      n_lo_reg         <= 8'd0;
      n_reg            <= '0;
      byte_idx_reg     <= 2'd0;
      asm_reg          <= 24'd0;
      csum_reg         <= 8'd0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wdata_reg    <= 32'd0;
      words_loaded_reg <= '0;
      cpu_reset_reg    <= 1'b1;
      load_done_reg    <= 1'b0;
      load_error_reg   <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      case (state_reg)
        HDR_LO: begin
          if (accept) begin
            n_lo_reg  <= bus.in_data;
            state_reg <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            if (hdr_bad) begin
              state_reg      <= ERROR;
              load_error_reg <= 1'b1;
            end else begin
              n_reg            <= CNT_W'(hdr_n);
              byte_idx_reg     <= 2'd0;
              words_loaded_reg <= '0;
              state_reg        <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum_reg     <= csum_reg + bus.in_data;
            asm_reg      <= {bus.in_data, asm_reg[23:8]};
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              mem_we_reg       <= 1'b1;
              mem_addr_reg     <= words_loaded_reg[ADDR_WIDTH-1:0];
              mem_wdata_reg    <= {bus.in_data, asm_reg};
              words_loaded_reg <= words_loaded_reg + CNT_W'(1);
              if (last_word) begin
                state_reg <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.in_data == csum_reg) begin
              state_reg     <= DONE;
              load_done_reg <= 1'b1;
              cpu_reset_reg <= 1'b0;
            end else begin
              state_reg      <= ERROR;
              load_error_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        ERROR: begin
          state_reg <= ERROR;
        end
        default: begin
          state_reg      <= ERROR;
          load_error_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = ready;
  assign bus.mem_we       = mem_we_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_wdata    = mem_wdata_reg;
  assign bus.cpu_reset    = cpu_reset_reg;
  assign bus.load_done    = load_done_reg;
  assign bus.load_error   = load_error_reg;
  assign bus.words_loaded = words_loaded_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random boot streams compared
// against a stream-level model of the expected memory writes and final status.
module tb_prog_loader;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  prog_loader_if #(.ADDR_WIDTH(8)) intf ();

  prog_loader #(.ADDR_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.master)
  );

  always #5 clk = ~clk;

  logic [39:0] wr_q[$];
  logic [39:0] exp_q[$];
  int          exp_acc;
  logic        exp_done;
  logic        exp_err;
  int          exp_wl;

  always @(negedge clk) begin
    if (!reset && intf.mem_we) wr_q.push_back({intf.mem_addr, intf.mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stream-level model: what a correct loader writes and how it ends up.
  task automatic model(input bq_t s);
    int n;
    logic [7:0] sum;
    exp_q.delete();
    n = int'(s[0]) + 256 * int'(s[1]);
    sum = 8'd0;
    if (n == 0 || n > 256) begin
      exp_acc = 2; exp_done = 1'b0; exp_err = 1'b1; exp_wl = 0;
    end else begin
      for (int w = 0; w < n; w++) begin
        logic [31:0] word;
        word = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
        exp_q.push_back({8'(w), word});
        for (int k = 0; k < 4; k++) sum = sum + s[2+4*w+k];
      end
      exp_acc  = 2 + 4 * n + 1;
      exp_done = (s[2+4*n] == sum);
      exp_err  = !exp_done;
      exp_wl   = n;
    end
  endtask

  task automatic send(input bq_t s, input int max_gap, output int acc);
    int t;
    acc = 0;
    foreach (s[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        intf.in_valid = 1'b0;
        @(negedge clk);
      end
      intf.in_valid = 1'b1;
      intf.in_data  = s[i];
      t = 0;
      while (!intf.in_ready && t < 4) begin
        @(negedge clk);
        t++;
      end
      if (!intf.in_ready) break;
      @(negedge clk);
      acc++;
    end
    intf.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    intf.in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", intf.in_ready, 0);
    check("rst_cpu_reset", intf.cpu_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", intf.in_ready, 1);
    check("idle_flags", {intf.load_done, intf.load_error, intf.mem_we}, 3'b000);
    check("idle_words", intf.words_loaded, 0);
  endtask

  task automatic run_and_check(input string name, input bq_t s, input int max_gap);
    int acc;
    model(s);
    send(s, max_gap, acc);
    repeat (3) @(negedge clk);
    check({name, "_accepted"}, acc, exp_acc);
    check({name, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({name, "_write"}, wr_q[i], exp_q[i]);
    check({name, "_done"}, intf.load_done, exp_done);
    check({name, "_error"}, intf.load_error, exp_err);
    check({name, "_cpu_reset"}, intf.cpu_reset, !exp_done);
    check({name, "_in_ready"}, intf.in_ready, 0);
    check({name, "_words"}, intf.words_loaded, exp_wl);
    $display("stream %s: %0d bytes, %0d writes, done=%0b error=%0b",
             name, s.size(), wr_q.size(), intf.load_done, intf.load_error);
  endtask

  initial begin
    bq_t s1, s;
    int acc;
    intf.in_valid = 1'b0;
    intf.in_data  = 8'h00;
    s1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h97};

    do_reset(); wr_q.delete();
    run_and_check("t2_badsum", '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                 8'h13, 8'h01, 8'hA0, 8'h00, 8'h98}, 0);
    do_reset(); wr_q.delete();
    run_and_check("t3_n0", '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    do_reset(); wr_q.delete();
    run_and_check("t3_n257", '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    do_reset(); wr_q.delete();
    run_and_check("t4_gaps", s1, 5);

    // Abort a load mid-word with reset, then load a fresh one-word image.
    do_reset(); wr_q.delete();
    send('{8'h02, 8'h00, 8'h93, 8'h00, 8'h50}, 0, acc);
    do_reset();
    run_and_check("t5_abort", '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38}, 0);

    do_reset(); wr_q.delete();
    run_and_check("t1_basic", s1, 0);
    for (int c = 0; c < 10; c++) begin
      intf.in_valid = 1'b1;
      intf.in_data  = 8'($urandom);
      @(negedge clk);
      check("t6_in_ready", intf.in_ready, 0);
      check("t6_mem_we", intf.mem_we, 0);
      check("t6_done", intf.load_done, 1);
      check("t6_words", intf.words_loaded, 2);
    end
    intf.in_valid = 1'b0;

    for (int r = 0; r < 12; r++) begin
      int kind, n;
      logic [7:0] sum;
      s.delete();
      kind = $urandom_range(0, 9);
      if (kind == 0) n = 0;
      else if (kind == 1) n = 257 + $urandom_range(0, 1000);
      else n = $urandom_range(1, 6);
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      sum = 8'd0;
      for (int k = 0; k < 4 * ((n > 256) ? 1 : (n == 0 ? 1 : n)); k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        sum = sum + b;
        s.push_back(b);
      end
      if ($urandom_range(0, 2) == 0) sum = sum ^ 8'(1 + $urandom_range(0, 254));
      s.push_back(sum);
      do_reset(); wr_q.delete();
      run_and_check($sformatf("rand%0d", r), s, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
